intr_service_sequencer: RTL and testbench
=========================================

// Module: intr_service_sequencer
// PURPOSE
//  Hardware AXI4-Lite master that configures and services the InterruptMultiReg slave
//  without a CPU: enables it, waits for irq, reads PENDING, dispatches the winning source
//  to a downstream handler, writes ACK, and re-reads PENDING to confirm the clear.
//  Sits between the interrupt slave's S_AXI_INTR port and local service logic.
// PARAMETERS
//  BASE_ADDR         32'h44A0_0000  byte base of the interrupt slave register block
//  NUM_INTR          4              interrupt sources handled (1..32)
//  IRQ_ACTIVE_STATE  1'b1           irq level that means "asserted"
//  TIMEOUT_CYCLES    1024           response watchdog limit (only with INTR_SEQ_TIMEOUT_EN)
// PORTS
//  ACLK           in   1         clock
//  ARESET         in   1         reset, asynchronous, active-high
//  cfg_start      in   1         1-cycle pulse: (re)configure slave, leave IDLE/ERR
//  intr_en_mask   in   NUM_INTR  value written to INTREN; also masks PENDING
//  irq            in   1         interrupt line from slave (ACLK domain)
//  svc_valid      out  1         dispatch request valid
//  svc_id         out  5         index of dispatched source
//  svc_ready      in   1         handler accepts dispatch
//  busy           out  1         FSM not in IDLE/WAIT_IRQ
//  err            out  1         sticky; set on bad resp, clear-fail or timeout
//  err_code       out  2         0 none, 1 SLVERR/DECERR, 2 ack not cleared, 3 timeout
//  m_axi_aw{addr[32],prot[3],valid,ready} / w{data[32],strb[4],valid,ready} /
//  b{resp[2],valid,ready} / ar{addr[32],prot[3],valid,ready} / r{data[32],resp[2],valid,ready}
//                                standard AXI4-Lite master channels
// BEHAVIOUR
//  Reset: FSM=IDLE; all VALID/READY outs, svc_valid, busy, err = 0; svc_id, err_code = 0.
//  FSM: IDLE -cfg_start-> CFG_GEN (write 1 @ BASE+0x00) -> CFG_IEN (write
//   intr_en_mask @ +0x04) -> WAIT_IRQ -irq==IRQ_ACTIVE_STATE-> RD_PEND (read +0x10)
//   -> DISPATCH -> WR_ACK (write one-hot(svc_id) @ +0x0C) -> RD_VERIFY (read +0x10)
//   -> DISPATCH if another masked bit set, else WAIT_IRQ.
//  RD_PEND with (rdata & mask)==0: spurious, return to WAIT_IRQ, no dispatch.
//  Priority: lowest set index of (rdata & mask) wins; svc_id registered at R handshake.
//  DISPATCH: svc_valid high the cycle after entry, held with stable svc_id until svc_ready.
//  RD_VERIFY: bit svc_id still set -> ERR, err_code=2.
//  Write: AWVALID and WVALID rise together; each drops on its own READY; BREADY high
//   once both accepted; transaction ends on BVALID&&BREADY. WSTRB=4'hF, *PROT=0.
//  Read: ARVALID held until ARREADY; RREADY high until RVALID; ends on RVALID&&RREADY.
//  Any BRESP/RRESP != OKAY -> ERR, err_code=1. One outstanding transaction max.
//  Latency: irq sampled active -> ARVALID next cycle.
//  ERR: no bus activity, svc_valid=0; cfg_start clears err/err_code, goes to CFG_GEN.
//  cfg_start outside IDLE/ERR ignored. ARESET mid-burst drops all VALIDs immediately.
//  irq staying active after WAIT_IRQ re-entry starts a new RD_PEND (level-sensitive).
// CONFIGURATION
//  INTR_SEQ_TIMEOUT_EN defined: counter per AXI transaction; TIMEOUT_CYCLES without
//   completion -> drop VALIDs, ERR, err_code=3. Undefined: no counter, waits forever,
//   err_code 3 never produced.
// STRUCTURE
//  Package intr_seq_pkg: register offsets (GIE 0x00, IEN 0x04, ACK 0x0C, PEND 0x10),
//   state enum, err_code enum, AXI resp constants.
//  Sub-module axil_single_master: one-transaction AXI4-Lite engine (start, wr, addr,
//   wdata -> done, rdata, resp); sequencer FSM drives it.
// TESTING
//  cfg_start, mask=4'b0101 -> writes 1 @0x44A00000 then 5 @0x44A00004, FSM in WAIT_IRQ.
//  irq, PEND=0x5 -> svc_id=0, ACK write 0x1; verify PEND=0x4 -> svc_id=2, ACK 0x4; back
//   to WAIT_IRQ.
//  irq, PEND=0x2 with mask 0x5 -> spurious, no svc_valid, no ACK write.
//  svc_ready held low 20 cycles -> svc_valid/svc_id stable 20 cycles, no ACK issued.
//  BRESP=SLVERR on IEN write -> err=1, err_code=1; cfg_start clears and reconfigures.
//  With INTR_SEQ_TIMEOUT_EN, RVALID never returned -> err_code=3 after 1024 cycles.

Source files
------------

// File: rtl/intr_seq_pkg.sv
// Shared definitions for the interrupt service sequencer: slave register map,
// sequencer states, error codes, AXI response encodings and a priority helper.
package intr_seq_pkg;

  // Byte offsets of the interrupt slave registers
  localparam logic [31:0] REG_GIE  = 32'h0000_0000;
  localparam logic [31:0] REG_IEN  = 32'h0000_0004;
  localparam logic [31:0] REG_ACK  = 32'h0000_000C;
  localparam logic [31:0] REG_PEND = 32'h0000_0010;

  // AXI response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_GEN,
    ST_CFG_IEN,
    ST_WAIT_IRQ,
    ST_RD_PEND,
    ST_DISPATCH,
    ST_WR_ACK,
    ST_RD_VERIFY,
    ST_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RESP    = 2'd1,
    ERR_ACK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  // Index of the lowest set bit; 0 when nothing is set
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axil_single_master.sv
// Single-transaction AXI4-Lite master engine. A start pulse launches one read
// or write; done pulses (combinationally) on the final handshake with rdata/resp
// valid in that same cycle. Optional watchdog: INTR_SEQ_TIMEOUT_EN.
module axil_single_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  output logic        timeout,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  logic [31:0] addr_reg, wdata_reg;
  logic aw_valid_reg, w_valid_reg, b_ready_reg, ar_valid_reg, r_ready_reg, wr_active_reg;
  logic b_done, r_done, aw_pend, w_pend, active;

  assign b_done  = b_ready_reg && m_axi_bvalid;
  assign r_done  = r_ready_reg && m_axi_rvalid;
  assign aw_pend = aw_valid_reg && !m_axi_awready;
  assign w_pend  = w_valid_reg && !m_axi_wready;
  assign active  = wr_active_reg || ar_valid_reg || r_ready_reg;
  assign done    = b_done || r_done;
  assign rdata   = m_axi_rdata;
  assign resp    = r_ready_reg ? m_axi_rresp : m_axi_bresp;

  assign m_axi_awaddr  = addr_reg;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awvalid = aw_valid_reg;
  assign m_axi_wvalid  = w_valid_reg;
  assign m_axi_bready  = b_ready_reg;
  assign m_axi_arvalid = ar_valid_reg;
  assign m_axi_rready  = r_ready_reg;

  // Channel handshake state: launch on start, retire each VALID on its READY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      aw_valid_reg  <= 1'b0;
      w_valid_reg   <= 1'b0;
      b_ready_reg   <= 1'b0;
      ar_valid_reg  <= 1'b0;
      r_ready_reg   <= 1'b0;
      wr_active_reg <= 1'b0;
    end else if (timeout) begin
      aw_valid_reg  <= 1'b0;
      w_valid_reg   <= 1'b0;
      b_ready_reg   <= 1'b0;
      ar_valid_reg  <= 1'b0;
      r_ready_reg   <= 1'b0;
      wr_active_reg <= 1'b0;
    end else if (start) begin
      addr_reg  <= addr;
      wdata_reg <= wdata;
      if (wr) begin
        aw_valid_reg  <= 1'b1;
        w_valid_reg   <= 1'b1;
        wr_active_reg <= 1'b1;
      end else begin
        ar_valid_reg <= 1'b1;
      end
    end else begin
      aw_valid_reg <= aw_pend;
      w_valid_reg  <= w_pend;
      if (b_done) begin
        b_ready_reg   <= 1'b0;
        wr_active_reg <= 1'b0;
      end else if (wr_active_reg && !aw_pend && !w_pend) begin
        b_ready_reg <= 1'b1;
      end
      if (ar_valid_reg && m_axi_arready) begin
        ar_valid_reg <= 1'b0;
        r_ready_reg  <= 1'b1;
      end
      if (r_done) r_ready_reg <= 1'b0;
    end
  end

`ifdef INTR_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt_reg;

  assign timeout = active && !done && (wd_cnt_reg == TIMEOUT_CYCLES - 1);

  // Watchdog: cycles spent in the current transaction
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wd_cnt_reg <= 32'd0;
    end else if (start || !active || timeout) begin
      wd_cnt_reg <= 32'd0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + 32'd1;
    end
  end
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = ^TIMEOUT_CYCLES ^ active;
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/intr_service_sequencer.sv
// CPU-less AXI4-Lite master that configures the interrupt slave, services irq by
// reading PENDING, dispatching the lowest enabled source, acknowledging it and
// re-reading PENDING to confirm the clear. Optional watchdog: INTR_SEQ_TIMEOUT_EN.
module intr_service_sequencer
  import intr_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h44A0_0000,
  parameter int unsigned NUM_INTR         = 4,
  parameter logic        IRQ_ACTIVE_STATE = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cfg_start,
  input  logic [NUM_INTR-1:0] intr_en_mask,
  input  logic                irq,
  output logic                svc_valid,
  output logic [4:0]          svc_id,
  input  logic                svc_ready,
  output logic                busy,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [31:0]         m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [31:0]         m_axi_wdata,
  output logic [3:0]          m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [31:0]         m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [31:0]         m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  seq_state_t  state_reg, state_next;
  err_code_t   err_code_reg, err_code_set, fault_code;
  logic        svc_valid_reg, busy_reg, err_reg;
  logic [4:0]  svc_id_reg;
  logic        bus_start, bus_wr, bus_done, bus_timeout, bus_fault;
  logic        err_set, load_id;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, mask32, masked;
  logic [1:0]  bus_resp;

  assign mask32     = 32'(intr_en_mask);
  assign masked     = bus_rdata & mask32;
  assign bus_fault  = bus_timeout || (bus_done && bus_resp != RESP_OKAY);
  assign fault_code = bus_timeout ? ERR_TIMEOUT : ERR_RESP;

  assign svc_valid = svc_valid_reg;
  assign svc_id    = svc_id_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;
  assign err_code  = err_code_reg;

  axil_single_master #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_master (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .start         (bus_start),
    .wr            (bus_wr),
    .addr          (bus_addr),
    .wdata         (bus_wdata),
    .done          (bus_done),
    .rdata         (bus_rdata),
    .resp          (bus_resp),
    .timeout       (bus_timeout),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  // Next state plus the bus request launched on the transition into each bus state
  always_comb begin
    state_next   = state_reg;
    bus_start    = 1'b0;
    bus_wr       = 1'b0;
    bus_addr     = BASE_ADDR + REG_PEND;
    bus_wdata    = 32'd0;
    err_set      = 1'b0;
    err_code_set = ERR_NONE;
    load_id      = 1'b0;
    case (state_reg)
      ST_IDLE, ST_ERR: begin
        if (cfg_start) begin
          state_next = ST_CFG_GEN;
          bus_start  = 1'b1;
          bus_wr     = 1'b1;
          bus_addr   = BASE_ADDR + REG_GIE;
          bus_wdata  = 32'd1;
        end
      end
      ST_CFG_GEN: begin
        if (bus_fault) begin
          state_next = ST_ERR; err_set = 1'b1; err_code_set = fault_code;
        end else if (bus_done) begin
          state_next = ST_CFG_IEN;
          bus_start  = 1'b1;
          bus_wr     = 1'b1;
          bus_addr   = BASE_ADDR + REG_IEN;
          bus_wdata  = mask32;
        end
      end
      ST_CFG_IEN: begin
        if (bus_fault) begin
          state_next = ST_ERR; err_set = 1'b1; err_code_set = fault_code;
        end else if (bus_done) begin
          state_next = ST_WAIT_IRQ;
        end
      end
      ST_WAIT_IRQ: begin
        if (irq == IRQ_ACTIVE_STATE) begin
          state_next = ST_RD_PEND;
          bus_start  = 1'b1;
        end
      end
      ST_RD_PEND: begin
        if (bus_fault) begin
          state_next = ST_ERR; err_set = 1'b1; err_code_set = fault_code;
        end else if (bus_done) begin
          if (masked == 32'd0) begin
            state_next = ST_WAIT_IRQ;
          end else begin
            state_next = ST_DISPATCH;
            load_id    = 1'b1;
          end
        end
      end
      ST_DISPATCH: begin
        if (svc_valid_reg && svc_ready) begin
          state_next = ST_WR_ACK;
          bus_start  = 1'b1;
          bus_wr     = 1'b1;
          bus_addr   = BASE_ADDR + REG_ACK;
          bus_wdata  = 32'd1 << svc_id_reg;
        end
      end
      ST_WR_ACK: begin
        if (bus_fault) begin
          state_next = ST_ERR; err_set = 1'b1; err_code_set = fault_code;
        end else if (bus_done) begin
          state_next = ST_RD_VERIFY;
          bus_start  = 1'b1;
        end
      end
      ST_RD_VERIFY: begin
        if (bus_fault) begin
          state_next = ST_ERR; err_set = 1'b1; err_code_set = fault_code;
        end else if (bus_done) begin
          if (bus_rdata[svc_id_reg]) begin
            state_next = ST_ERR; err_set = 1'b1; err_code_set = ERR_ACK;
          end else if (masked != 32'd0) begin
            state_next = ST_DISPATCH;
            load_id    = 1'b1;
          end else begin
            state_next = ST_WAIT_IRQ;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sequencer registers and registered status/dispatch outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg     <= ST_IDLE;
      svc_valid_reg <= 1'b0;
      svc_id_reg    <= 5'd0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      busy_reg  <= !(state_next inside {ST_IDLE, ST_WAIT_IRQ});
      if (load_id) svc_id_reg <= lowest_set(masked);
      svc_valid_reg <= (state_reg == ST_DISPATCH) && !(svc_valid_reg && svc_ready);
      if (err_set) begin
        err_reg      <= 1'b1;
        err_code_reg <= err_code_set;
      end else if (state_reg == ST_ERR && cfg_start) begin
        err_reg      <= 1'b0;
        err_code_reg <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_intr_service_sequencer.sv
// Directed bench for intr_service_sequencer: the bench plays the AXI4-Lite slave
// step by step and checks every address, data and status with immediate assertions.
module tb_intr_service_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_start;
  logic [3:0]  intr_en_mask;
  logic        irq;
  logic        svc_valid;
  logic [4:0]  svc_id;
  logic        svc_ready;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] A_GIE  = 32'h44A0_0000;
  localparam logic [31:0] A_IEN  = 32'h44A0_0004;
  localparam logic [31:0] A_ACK  = 32'h44A0_000C;
  localparam logic [31:0] A_PEND = 32'h44A0_0010;

  always #5 ACLK = ~ACLK;

  intr_service_sequencer dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .intr_en_mask  (intr_en_mask),
    .irq           (irq),
    .svc_valid     (svc_valid),
    .svc_id        (svc_id),
    .svc_ready     (svc_ready),
    .busy          (busy),
    .err           (err),
    .err_code      (err_code),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Accept one write, check address/data/strobe/prot, answer with bresp
  task automatic do_write(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                          input logic [1:0] br);
    int n;
    n = 0;
    while (!(m_axi_awvalid && m_axi_wvalid) && n < 200) begin tick(); n++; end
    chk({tag, "_awwvalid"}, 32'(m_axi_awvalid && m_axi_wvalid), 1);
    chk({tag, "_addr"}, m_axi_awaddr, ea);
    chk({tag, "_data"}, m_axi_wdata, ed);
    chk({tag, "_strb_prot"}, {25'd0, m_axi_awprot, m_axi_wstrb}, 32'h0000_000F);
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    tick();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    chk({tag, "_valid_drop"}, 32'(m_axi_awvalid || m_axi_wvalid), 0);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = br;
    n = 0;
    while (!m_axi_bready && n < 50) begin tick(); n++; end
    chk({tag, "_bready"}, 32'(m_axi_bready), 1);
    tick();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    $display("write %s addr=%08h data=%08h bresp=%0d", tag, ea, ed, br);
  endtask

  // Accept one read, check address, return rd with OKAY
  task automatic do_read(input string tag, input logic [31:0] ea, input logic [31:0] rd);
    int n;
    n = 0;
    while (!m_axi_arvalid && n < 200) begin tick(); n++; end
    chk({tag, "_arvalid"}, 32'(m_axi_arvalid), 1);
    chk({tag, "_araddr"}, m_axi_araddr, ea);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b1;
    m_axi_rdata   = rd;
    m_axi_rresp   = 2'b00;
    n = 0;
    while (!m_axi_rready && n < 50) begin tick(); n++; end
    chk({tag, "_rready"}, 32'(m_axi_rready), 1);
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rdata  = 32'd0;
    $display("read  %s addr=%08h data=%08h", tag, ea, rd);
  endtask

  // Wait for a dispatch, check its id, then accept it
  task automatic take_dispatch(input string tag, input logic [4:0] eid);
    int n;
    n = 0;
    while (!svc_valid && n < 20) begin tick(); n++; end
    chk({tag, "_svc_valid"}, 32'(svc_valid), 1);
    chk({tag, "_svc_id"}, 32'(svc_id), 32'(eid));
    svc_ready = 1'b1;
    tick();
    svc_ready = 1'b0;
    chk({tag, "_svc_valid_drop"}, 32'(svc_valid), 0);
    $display("dispatch %s id=%0d", tag, svc_id);
  endtask

  task automatic pulse_cfg();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic pulse_irq(input string tag);
    irq = 1'b1;
    tick();
    irq = 1'b0;
    chk({tag, "_irq_to_ar"}, 32'(m_axi_arvalid), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_watchdog: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int bad;
    ARESET = 1'b1;
    cfg_start = 1'b0; intr_en_mask = 4'b0101; irq = 1'b0; svc_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = 32'd0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;
    tick();
    tick();
    chk("reset_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("reset_status", {23'd0, svc_valid, svc_id, busy, err, err_code}, 0);
    ARESET = 1'b0;
    tick();
    $display("reset released");

    // Configure with mask 0101
    pulse_cfg();
    chk("cfg_busy", 32'(busy), 1);
    do_write("cfg_gie", A_GIE, 32'd1, 2'b00);
    do_write("cfg_ien", A_IEN, 32'd5, 2'b00);
    chk("cfg_wait_irq_busy", 32'(busy), 0);

    // PEND=5 -> source 0, then verify shows 4 -> source 2
    pulse_irq("svc1");
    chk("svc1_busy", 32'(busy), 1);
    do_read("svc1_pend", A_PEND, 32'h5);
    take_dispatch("svc1_d0", 5'd0);
    do_write("svc1_ack0", A_ACK, 32'h1, 2'b00);
    do_read("svc1_ver0", A_PEND, 32'h4);
    take_dispatch("svc1_d2", 5'd2);
    do_write("svc1_ack2", A_ACK, 32'h4, 2'b00);
    do_read("svc1_ver2", A_PEND, 32'h0);
    chk("svc1_back_idle", 32'(busy), 0);

    // Spurious: PEND=2 masked out by 0101
    pulse_irq("spur");
    do_read("spur_pend", A_PEND, 32'h2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (svc_valid || m_axi_awvalid || m_axi_arvalid) bad++;
    end
    chk("spur_no_activity", 32'(bad), 0);

    // Handler stalls 20 cycles
    pulse_irq("stall");
    do_read("stall_pend", A_PEND, 32'h1);
    while (!svc_valid && bad < 20) begin tick(); bad++; end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (svc_valid !== 1'b1 || svc_id !== 5'd0 || m_axi_awvalid) bad++;
    end
    chk("stall_stable", 32'(bad), 0);
    take_dispatch("stall_d0", 5'd0);
    do_write("stall_ack", A_ACK, 32'h1, 2'b00);
    do_read("stall_ver", A_PEND, 32'h0);

    // ACK not honoured: verify still shows bit 0
    pulse_irq("noclr");
    do_read("noclr_pend", A_PEND, 32'h1);
    take_dispatch("noclr_d0", 5'd0);
    do_write("noclr_ack", A_ACK, 32'h1, 2'b00);
    do_read("noclr_ver", A_PEND, 32'h1);
    chk("noclr_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd2});

    // Restart from ERR, SLVERR on IEN write
    pulse_cfg();
    chk("slv_err_cleared", {29'd0, err, err_code}, 0);
    do_write("slv_gie", A_GIE, 32'd1, 2'b00);
    do_write("slv_ien", A_IEN, 32'd5, 2'b10);
    chk("slv_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
    irq = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_axi_awvalid || m_axi_arvalid || svc_valid) bad++;
    end
    irq = 1'b0;
    chk("err_quiet", 32'(bad), 0);
    pulse_cfg();
    do_write("rcfg_gie", A_GIE, 32'd1, 2'b00);
    do_write("rcfg_ien", A_IEN, 32'd5, 2'b00);
    chk("rcfg_ok", {29'd0, busy, err_code}, 0);

    // Level-sensitive irq: held high through a spurious read
    irq = 1'b1;
    tick();
    do_read("lvl_pend1", A_PEND, 32'h0);
    tick();
    chk("lvl_reread", 32'(m_axi_arvalid), 1);
    irq = 1'b0;
    do_read("lvl_pend2", A_PEND, 32'h0);

    // cfg_start ignored while waiting for irq
    pulse_cfg();
    tick();
    tick();
    chk("cfg_ignored", {30'd0, m_axi_awvalid, busy}, 0);

    // Asynchronous reset in the middle of a read
    pulse_irq("arst");
    #2;
    ARESET = 1'b1;
    #1;
    chk("arst_drop", {29'd0, m_axi_arvalid, m_axi_rready, busy}, 0);
    tick();
    ARESET = 1'b0;
    tick();
    $display("mid-burst reset done");

`ifdef INTR_SEQ_TIMEOUT_EN
    pulse_cfg();
    do_write("to_gie", A_GIE, 32'd1, 2'b00);
    do_write("to_ien", A_IEN, 32'd5, 2'b00);
    pulse_irq("to");
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    bad = 0;
    while (!err && bad < 1200) begin tick(); bad++; end
    chk("to_err_code", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd3});
    chk("to_window", 32'(bad >= 1000 && bad <= 1030), 1);
    chk("to_rready_drop", 32'(m_axi_rready), 0);
    $display("timeout after %0d cycles", bad);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
